// File: rtl/reg_dump.sv
// Debug read-out sequencer: stalls the core, walks a register range through one
// register-file read port and streams (address, data) words over valid/ready.
module reg_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] Ra,
  input  logic [DATA_WIDTH-1:0] busA,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cur_reg, cur_next;
  logic [ADDR_WIDTH-1:0]   range_end_reg, range_end_next;
  logic [ADDR_WIDTH-1:0]   out_addr_reg, out_addr_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    handshake;
  logic                    active;

  assign handshake = out_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cur_reg       <= '0;
      range_end_reg <= '0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      range_end_reg <= range_end_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_next       = cur_reg;
    range_end_next = range_end_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cur_next       = first_reg;
          range_end_next = last_reg;
          state_next     = READ;
        end
      end
      READ: begin
        out_addr_next  = cur_reg;
        out_data_next  = busA;
        out_valid_next = 1'b1;
        state_next     = HOLD;
      end
      HOLD: begin
        // Word stays frozen until the consumer takes it; the range end is an
        // equality test so wrapped ranges (first > last) fall out naturally.
        if (handshake) begin
          out_valid_next = 1'b0;
          if (cur_reg == range_end_reg) begin
            state_next = DONE;
          end else begin
            cur_next   = cur_reg + 1'b1;
            state_next = READ;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign active    = (state_reg == READ) || (state_reg == HOLD);
  assign Ra        = active ? cur_reg : '0;
  assign stall     = active;
  assign busy      = active;
  assign done      = (state_reg == DONE);
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a register-file model feeds busA, expected words
// are queued when a dump is started and compared as each handshake happens.
module tb_reg_dump;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  Ra;
  logic [31:0] busA;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  word_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign busA = regs[Ra];

  reg_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_reg(first_reg), .last_reg(last_reg),
    .Ra(Ra), .busA(busA), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ra"},        {27'd0, Ra}, 32'd0);
    check({tag, "_stall"},     {31'd0, stall}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_out_addr"},  {27'd0, out_addr}, 32'd0);
    check({tag, "_out_data"},  out_data, 32'd0);
  endtask

  // mode 0: out_ready always high; mode 1: 5-cycle stall on word 2, then toggling.
  // inject: pulse start with a different range in READ, in HOLD and in DONE.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                         input bit check_timing, input bit inject);
    int    n;
    int    cyc;
    int    hs;
    int    wait_cnt;
    bit    held;
    bit    done_seen;
    bit    toggle;
    bit    rdy;
    logic [4:0]  held_addr;
    logic [31:0] held_data;
    logic [4:0]  a;
    word_t exp_w;

    n = int'(5'(l - f)) + 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = 5'(f + 5'(i));
      exp_q.push_back('{addr: a, data: regs[a]});
    end
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    out_ready = (mode == 0);
    step();
    start     = 1'b0;
    cyc       = 1;
    hs        = 0;
    wait_cnt  = 0;
    held      = 0;
    done_seen = 0;
    toggle    = 0;
    check("latency_ra_first", {27'd0, Ra}, {27'd0, f});
    while (!done_seen && cyc < 400) begin
      if (done) begin
        done_seen = 1;
        check("done_words", hs, n);
        check("done_queue_empty", exp_q.size(), 0);
        check("done_stall_low", {31'd0, stall}, 32'd0);
        check("done_ra_zero", {27'd0, Ra}, 32'd0);
        check("done_out_valid_low", {31'd0, out_valid}, 32'd0);
        if (check_timing) check("done_cycle", cyc, 2 * n + 1);
        if (inject) begin
          start     = 1'b1;
          first_reg = 5'd0;
          last_reg  = 5'd3;
        end
      end else begin
        check("stall_active", {31'd0, stall}, 32'd1);
        check("busy_eq_stall", {31'd0, busy}, {31'd0, stall});
        start = 1'b0;
        if (held) begin
          check("hold_addr_stable", {27'd0, out_addr}, {27'd0, held_addr});
          check("hold_data_stable", out_data, held_data);
        end
        if (out_valid) begin
          if (mode == 0) rdy = 1'b1;
          else if (hs == 1 && wait_cnt < 5) begin
            rdy = 1'b0;
            wait_cnt++;
          end else if (hs >= 2) begin
            toggle = ~toggle;
            rdy = toggle;
          end else rdy = 1'b1;
          out_ready = rdy;
          if (inject && hs == 1) begin
            start     = 1'b1;
            first_reg = 5'd20;
            last_reg  = 5'd21;
          end
          if (rdy) begin
            if (exp_q.size() == 0) begin
              check("extra_word", 32'd1, 32'd0);
            end else begin
              exp_w = exp_q.pop_front();
              check("word_addr", {27'd0, out_addr}, {27'd0, exp_w.addr});
              check("word_data", out_data, exp_w.data);
            end
            if (check_timing) check("handshake_cycle", cyc, 2 * (hs + 1));
            hs++;
            held = 0;
          end else begin
            held      = 1;
            held_addr = out_addr;
            held_data = out_data;
          end
        end else begin
          if (exp_q.size() != 0) check("read_ra", {27'd0, Ra}, {27'd0, exp_q[0].addr});
          out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          if (inject && hs == 0) begin
            start     = 1'b1;
            first_reg = 5'd7;
            last_reg  = 5'd2;
          end
        end
      end
      step();
      cyc++;
    end
    if (!done_seen) check("dump_timeout", 32'd1, 32'd0);
    start = 1'b0;
    check("post_done_pulse_low", {31'd0, done}, 32'd0);
    check("post_done_idle", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    first_reg = 5'd4;
    last_reg  = 5'd9;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
    step();
    step();
    check_reset_outputs("reset_priority");
    start = 1'b0;
    reset = 1'b0;
    step();
    check_reset_outputs("reset_idle");

    do_dump(5'd0, 5'd31, 0, 1'b1, 1'b0);
    regs[29] = 32'd252;
    do_dump(5'd29, 5'd29, 0, 1'b0, 1'b0);
    do_dump(5'd30, 5'd1, 0, 1'b0, 1'b0);
    do_dump(5'd4, 5'd12, 1, 1'b0, 1'b0);
    do_dump(5'd10, 5'd15, 0, 1'b0, 1'b1);
    do_dump(5'd16, 5'd18, 0, 1'b0, 1'b0);

    first_reg = 5'd0;
    last_reg  = 5'd31;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midreset_third_valid", {31'd0, out_valid}, 32'd1);
    check("midreset_third_addr", {27'd0, out_addr}, 32'd2);
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    check_reset_outputs("midreset");
    reset = 1'b0;
    step();
    check("midreset_no_done", {31'd0, done}, 32'd0);
    check("midreset_idle", {31'd0, stall}, 32'd0);
    do_dump(5'd3, 5'd6, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out sequencer for the 32-entry register file. On a start request it stalls the core and walks a register range through one register-file read port. It captures each value and streams it out as an (address, data) word over a valid/ready handshake. It sits between the register file's read port and the test/debug interface, as the reader counterpart to the file's write port.

## Interface

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  dump request, sampled only in IDLE
- first_reg  input  ADDR_WIDTH  first register of the range, latched on accepted start
- last_reg  input  ADDR_WIDTH  last register of the range, latched on accepted start
- Ra  output  ADDR_WIDTH  read address driven to the register file read port
- busA  input  DATA_WIDTH  read data returned combinationally from the register file
- stall  output  1  core stall request; high while a dump is in progress
- out_valid  output  1  out_addr/out_data hold a word
- out_ready  input  1  consumer accepts the word
- out_addr  output  ADDR_WIDTH  register number of the current word
- out_data  output  DATA_WIDTH  register value of the current word
- busy  output  1  dump in progress; equals stall
- done  output  1  one-cycle pulse after the last word is accepted

## Operation

- States: IDLE, READ, HOLD, DONE.
- IDLE:
  - On start=1, latch first_reg into cur and last_reg into last, then go to READ.
  - If start=0, remain in IDLE.
- READ:
  - Drive Ra=cur.
  - At the clock edge, capture busA into out_data and cur into out_addr, set out_valid=1, and go to HOLD.
- HOLD:
  - Hold out_valid, out_addr and out_data stable until out_ready=1.
  - On handshake (out_valid & out_ready) with cur==last: clear out_valid and go to DONE.
  - On handshake otherwise: cur <= cur+1 modulo 2**ADDR_WIDTH, clear out_valid, and go to READ.
- DONE: assert done for exactly one cycle, then go to IDLE unconditionally.
- Range semantics:
  - Word count is ((last - first) mod 32) + 1.
  - first==last dumps exactly one register.
  - first>last wraps: first..31, then 0..last.
  - first=0, last=31 dumps all 32 registers.
- Register 0 is dumped like any other register and must read 0.
- start asserted outside IDLE is ignored; it is neither queued nor used to restart the dump.
- Address and increment arithmetic is ADDR_WIDTH bits, unsigned, wrapping.
- The block never writes the register file.

## Timing

- Reset values:
  - state=IDLE, Ra=0, stall=0, busy=0, out_valid=0, done=0.
  - out_addr=0, out_data=0, cur=0, last=0.
- Reset asserted mid-dump: the next edge returns the block to IDLE with all outputs at their reset values. The word in flight is dropped and no done pulse is generated.
- Reset has priority over start on the same edge.
- Ra in IDLE and DONE is 0.
- stall and busy are high in READ and HOLD only; they are low in IDLE and DONE.
- Latency, with start seen at edge 0:
  - READ in cycle 1 with Ra=first.
  - First out_valid in cycle 2.
- With out_ready held high, throughput is one word per 2 cycles.
- The last handshake in cycle t gives done=1 in cycle t+1. stall falls in that same cycle t+1.
- A start in the DONE cycle is ignored. A start in the cycle after DONE (back in IDLE) is accepted.
- Backpressure: out_ready=0 holds HOLD indefinitely with out_* stable and stall held high.
- out_ready while out_valid=0 has no effect.

## Test plan

- Full dump:
  - Stimulus: preload r1..r31 = 0x1000+n, start with first=0, last=31, out_ready=1.
  - Required response: 32 words (0,0x0), (1,0x1001) ... (31,0x101F); handshakes in cycles 2,4,...,64; done=1 only in cycle 65; stall high in cycles 1-64.
- Single register:
  - Stimulus: first=last=29, r29=252.
  - Required response: exactly one word (29,252), then a done pulse.
- Wrap-around:
  - Stimulus: first=30, last=1.
  - Required response: words in order 30, 31, 0, 1, then done; no other addresses appear.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles on the second word, and toggling afterwards.
  - Required response: out_addr/out_data stable while out_valid=1 and out_ready=0; no word lost or duplicated; stall high throughout.
- Reset mid-dump:
  - Stimulus: assert reset in HOLD of the third word of a 0..31 dump.
  - Required response: next cycle all outputs at their reset values with no done pulse; a fresh start then dumps correctly from first_reg.
- Ignored start:
  - Stimulus: pulse start with different first/last during READ, during HOLD and in the DONE cycle.
  - Required response: the current range is unaffected and no second dump begins; a start one cycle after DONE begins a new dump.
